// File: rtl/clause_variable_scanner.sv
// Purpose: capture one clause's integer/boolean presence masks and stream the involved variable indices, integer first.
// Latency: a clause accepted at edge N presents its first index (or the empty-clause pulse) in cycle N+1, then one index per cycle.
// Backpressure: valid/ready on both sides; the presented index holds while in_index_ready is low; no clause is accepted while streaming.
module clause_variable_scanner #(
   parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 2,
   parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 2,
   parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
   parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2,
   localparam int IIW = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
   localparam int BIW = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
   localparam int CW  = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
   localparam int NI  = 2 ** IIW,
   localparam int NB  = 2 ** BIW,
   localparam int IW  = (IIW > BIW) ? IIW : BIW
) (
   input  logic             in_clk,
   input  logic             in_reset_n,
   input  logic [NI*CW-1:0] in_integer_coefficients,
   input  logic [NB*2-1:0]  in_boolean_coefficients,
   input  logic             in_clause_valid,
   output logic             out_clause_ready,
   input  logic             in_abort,
   output logic [NI-1:0]    out_integer_variables,
   output logic [NB-1:0]    out_boolean_variables,
   output logic [IIW:0]     out_integer_count,
   output logic [BIW:0]     out_boolean_count,
   output logic             out_index_valid,
   input  logic             in_index_ready,
   output logic [IW-1:0]    out_index,
   output logic             out_index_is_boolean,
   output logic             out_index_last,
   output logic             out_empty_clause
);

   typedef enum logic [1:0] {IDLE, SCAN, EMPTY} state_e;

   state_e          state_q, state_d;
   logic [NI-1:0]   int_mask_q, int_mask_d, int_work_q, int_work_d;
   logic [NB-1:0]   bool_mask_q, bool_mask_d, bool_work_q, bool_work_d;
   logic [IIW:0]    int_cnt_q, int_cnt_d;
   logic [BIW:0]    bool_cnt_q, bool_cnt_d;

   logic [NI-1:0]   int_det;
   logic [NB-1:0]   bool_det;
   logic [IIW:0]    int_det_cnt;
   logic [BIW:0]    bool_det_cnt;
   logic [IW-1:0]   sel_idx;
   logic            sel_is_bool;
   logic            sel_last;
   logic [NI-1:0]   int_work_pop;
   logic [NB-1:0]   bool_work_pop;

   // Presence detection and popcount of the clause on the inputs
   always_comb begin
      int_det      = '0;
      bool_det     = '0;
      int_det_cnt  = '0;
      bool_det_cnt = '0;
      for (int i = 0; i < NI; i++) begin
         int_det[i]  = |in_integer_coefficients[i*CW +: CW];
         int_det_cnt = int_det_cnt + {{IIW{1'b0}}, int_det[i]};
      end
      for (int j = 0; j < NB; j++) begin
         bool_det[j]  = in_boolean_coefficients[2*j+1];
         bool_det_cnt = bool_det_cnt + {{BIW{1'b0}}, bool_det[j]};
      end
   end

   // Pick the lowest remaining integer bit, else the lowest remaining boolean bit;
   // x & (x-1) drops the lowest set bit, giving both the post-transfer mask and the last-flag test
   always_comb begin
      sel_idx       = '0;
      sel_is_bool   = (int_work_q == '0);
      int_work_pop  = int_work_q & (int_work_q - NI'(1));
      bool_work_pop = bool_work_q & (bool_work_q - NB'(1));
      for (int i = NI - 1; i >= 0; i--) begin
         if (!sel_is_bool && int_work_q[i]) sel_idx = IW'(i);
      end
      for (int j = NB - 1; j >= 0; j--) begin
         if (sel_is_bool && bool_work_q[j]) sel_idx = IW'(j);
      end
      if (sel_is_bool) sel_last = (bool_work_pop == '0);
      else             sel_last = (int_work_pop == '0) && (bool_work_q == '0);
   end

   // Next-state, capture and working-mask update
   always_comb begin
      state_d     = state_q;
      int_mask_d  = int_mask_q;
      bool_mask_d = bool_mask_q;
      int_cnt_d   = int_cnt_q;
      bool_cnt_d  = bool_cnt_q;
      int_work_d  = int_work_q;
      bool_work_d = bool_work_q;
      case (state_q)
         IDLE: begin
            if (!in_abort && in_clause_valid) begin
               int_mask_d  = int_det;
               bool_mask_d = bool_det;
               int_cnt_d   = int_det_cnt;
               bool_cnt_d  = bool_det_cnt;
               int_work_d  = int_det;
               bool_work_d = bool_det;
               state_d     = ((int_det == '0) && (bool_det == '0)) ? EMPTY : SCAN;
            end
         end
         SCAN: begin
            if (in_abort) begin
               int_work_d  = '0;
               bool_work_d = '0;
               state_d     = IDLE;
            end else if (in_index_ready) begin
               if (sel_is_bool) bool_work_d = bool_work_pop;
               else             int_work_d  = int_work_pop;
               if (sel_last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and clause registers
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q     <= IDLE;
         int_mask_q  <= '0;
         bool_mask_q <= '0;
         int_cnt_q   <= '0;
         bool_cnt_q  <= '0;
         int_work_q  <= '0;
         bool_work_q <= '0;
      end else begin
         state_q     <= state_d;
         int_mask_q  <= int_mask_d;
         bool_mask_q <= bool_mask_d;
         int_cnt_q   <= int_cnt_d;
         bool_cnt_q  <= bool_cnt_d;
         int_work_q  <= int_work_d;
         bool_work_q <= bool_work_d;
      end
   end

   // Outputs; index fields read zero whenever no index is presented
   always_comb begin
      out_clause_ready      = (state_q == IDLE);
      out_index_valid       = (state_q == SCAN);
      out_empty_clause      = (state_q == EMPTY) && !in_abort;
      out_index             = out_index_valid ? sel_idx : '0;
      out_index_is_boolean  = out_index_valid && sel_is_bool;
      out_index_last        = out_index_valid && sel_last;
      out_integer_variables = int_mask_q;
      out_boolean_variables = bool_mask_q;
      out_integer_count     = int_cnt_q;
      out_boolean_count     = bool_cnt_q;
   end

endmodule
